frame_deserializer: RTL and testbench

FRAME_DESERIALIZER -- requirements
Module: frame_deserializer

---
 rtl/frame_deserializer_if.sv | 29 ++
 rtl/frame_deserializer.sv | 86 ++++++++
 tb/tb_frame_deserializer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/frame_deserializer_if.sv
// Bit-stream side and word side of the frame deserializer, grouped as one bus.
// The slave modport is the deserializer; the master modport drives bits and consumes words.
interface frame_deserializer_if #(
  parameter int DATA_WIDTH = 8
);
  localparam int CW = $clog2(DATA_WIDTH + 1);

  logic                  sampled_data;
  logic                  sampled;
  logic                  deser_en;
  logic                  clear;
  logic                  data_ack;
  logic [DATA_WIDTH-1:0] P_Data;
  logic                  data_valid;
  logic                  par_bit;
  logic [CW-1:0]         bit_cnt;
  logic                  busy;
  logic                  overrun;

  modport master (
    output sampled_data, sampled, deser_en, clear, data_ack,
    input  P_Data, data_valid, par_bit, bit_cnt, busy, overrun
  );

  modport slave (
    input  sampled_data, sampled, deser_en, clear, data_ack,
    output P_Data, data_valid, par_bit, bit_cnt, busy, overrun
  );
endinterface

// File: rtl/frame_deserializer.sv
// Collects strobed serial bits into DATA_WIDTH-bit words, with a parity bit,
// a one-cycle completion pulse and a sticky overrun flag for unacknowledged words.
module frame_deserializer #(
  parameter int DATA_WIDTH = 8,
  parameter bit MSB_FIRST  = 1'b0
) (
  input  logic                  CLK,
  input  logic                  Reset,
  frame_deserializer_if.slave   bus
);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(DATA_WIDTH - 1);

  logic [DATA_WIDTH-1:0] shift_q, shift_nxt;
  logic [DATA_WIDTH-1:0] data_q;
  logic [CW-1:0]         cnt_q;
  logic                  par_q, dv_q, pending_q, overrun_q;
  logic                  accept, last_bit, complete;

  // clear wins over everything, so it also vetoes acceptance of a strobe
  assign accept   = bus.deser_en & bus.sampled & ~bus.clear;
  assign last_bit = (cnt_q == LAST_CNT);
  assign complete = accept & last_bit;

  generate
    if (MSB_FIRST) begin : g_msb
      assign shift_nxt = {shift_q[DATA_WIDTH-2:0], bus.sampled_data};
    end else begin : g_lsb
      assign shift_nxt = {bus.sampled_data, shift_q[DATA_WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      cnt_q <= '0;
    end else if (bus.clear || !bus.deser_en) begin
      cnt_q <= '0;
    end else if (accept) begin
      cnt_q <= last_bit ? '0 : cnt_q + CW'(1);
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset)         shift_q <= '0;
    else if (bus.clear) shift_q <= '0;
    else if (accept)    shift_q <= shift_nxt;
  end

  // Output word and parity only move on completion; clear leaves them alone
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      data_q <= '0;
      par_q  <= 1'b0;
    end else if (complete) begin
      data_q <= shift_nxt;
      par_q  <= ^shift_nxt;
    end
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) dv_q <= 1'b0;
    else        dv_q <= complete;
  end

  // An ack arriving with a new completion refers to the old word: the new one stays pending
  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else if (bus.clear) begin
      pending_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      if (complete)          pending_q <= 1'b1;
      else if (bus.data_ack) pending_q <= 1'b0;
      if (complete && pending_q && !bus.data_ack) overrun_q <= 1'b1;
    end
  end

  assign bus.P_Data     = data_q;
  assign bus.par_bit    = par_q;
  assign bus.data_valid = dv_q;
  assign bus.bit_cnt    = cnt_q;
  assign bus.busy       = |cnt_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: tb/tb_frame_deserializer.sv
// Directed bench: two 8-bit instances (LSB/MSB first) share a bit stream, a 5-bit
// instance has its own enable; expected words are hand-computed constants.
module tb_frame_deserializer;
  logic CLK = 1'b0, Reset = 1'b0;
  logic sd = 1'b0, smp = 1'b0, clr = 1'b0, ack = 1'b0, en_a = 1'b0, en_b = 1'b0;
  int   n_cmp = 0, n_bad = 0;
  int   dv_a = 0, dv_b = 0;

  always #5 CLK = ~CLK;

  frame_deserializer_if #(.DATA_WIDTH(8)) ifl ();
  frame_deserializer_if #(.DATA_WIDTH(8)) ifm ();
  frame_deserializer_if #(.DATA_WIDTH(5)) ifb ();

  assign ifl.sampled_data = sd;  assign ifm.sampled_data = sd;  assign ifb.sampled_data = sd;
  assign ifl.sampled = smp;      assign ifm.sampled = smp;      assign ifb.sampled = smp;
  assign ifl.clear = clr;        assign ifm.clear = clr;        assign ifb.clear = clr;
  assign ifl.data_ack = ack;     assign ifm.data_ack = ack;     assign ifb.data_ack = ack;
  assign ifl.deser_en = en_a;    assign ifm.deser_en = en_a;    assign ifb.deser_en = en_b;

  frame_deserializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b0)) u_l (.CLK(CLK), .Reset(Reset), .bus(ifl));
  frame_deserializer #(.DATA_WIDTH(8), .MSB_FIRST(1'b1)) u_m (.CLK(CLK), .Reset(Reset), .bus(ifm));
  frame_deserializer #(.DATA_WIDTH(5), .MSB_FIRST(1'b0)) u_b (.CLK(CLK), .Reset(Reset), .bus(ifb));

  always @(posedge CLK) begin
    if (ifl.data_valid) dv_a <= dv_a + 1;
    if (ifb.data_valid) dv_b <= dv_b + 1;
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // one strobe, optionally with data_ack in the same cycle; returns 1 after the accept edge
  task automatic send_bit(input logic b, input logic a);
    @(posedge CLK); #1 sd = b; smp = 1'b1; ack = a;
    @(posedge CLK); #1 smp = 1'b0; ack = 1'b0;
  endtask

  task automatic send_word(input logic [8:0] v, input int n, input logic ack_last);
    for (int i = 0; i < n; i++) send_bit(v[i], ack_last && (i == n - 1));
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic pulse_ack();
    @(posedge CLK); #1 ack = 1'b1;
    @(posedge CLK); #1 ack = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #22;
    check("rst_pdata",   ifl.P_Data, 16'h0);
    check("rst_cnt",     ifl.bit_cnt, 16'h0);
    check("rst_dv_ovr",  {ifl.data_valid, ifl.overrun, ifl.busy, ifl.par_bit}, 16'h0);
    check("rst_5b",      {ifb.P_Data, ifb.overrun}, 16'h0);
    Reset = 1'b1;
    idle(1);

    // 1,0,1,0,1,1,0,0 in arrival order
    en_a = 1'b1;
    send_word(9'h035, 8, 1'b0);
    check("w1_dv",       ifl.data_valid, 16'h1);
    check("w1_lsb",      ifl.P_Data, 16'h35);
    check("w1_msb",      ifm.P_Data, 16'hAC);
    check("w1_par",      {ifl.par_bit, ifm.par_bit}, 16'h0);
    check("w1_cnt",      {ifl.bit_cnt, ifl.busy}, 16'h0);
    idle(1);
    check("w1_dv_drop",  ifl.data_valid, 16'h0);
    check("w1_dv_cnt",   dv_a, 16'd1);

    // partial word, enable drop, then all ones
    pulse_ack();
    send_word(9'h007, 3, 1'b0);
    check("part_cnt",    ifl.bit_cnt, 16'd3);
    check("part_busy",   ifl.busy, 16'h1);
    en_a = 1'b0;
    idle(1);
    check("drop_cnt",    {ifl.bit_cnt, ifl.busy}, 16'h0);
    check("drop_hold",   ifl.P_Data, 16'h35);
    en_a = 1'b1;
    send_word(9'h0FF, 8, 1'b0);
    check("ff_lsb",      ifl.P_Data, 16'hFF);
    check("ff_msb",      ifm.P_Data, 16'hFF);
    check("ff_par_ovr",  {ifl.par_bit, ifl.overrun}, 16'h0);
    idle(1);
    check("ff_dv_cnt",   dv_a, 16'd2);

    // overrun: two words with no ack in between
    pulse_ack();
    send_word(9'h001, 8, 1'b0);
    check("ov1_ovr",     ifl.overrun, 16'h0);
    send_word(9'h002, 8, 1'b0);
    check("ov2_ovr",     ifl.overrun, 16'h1);
    check("ov2_pdata",   ifl.P_Data, 16'h02);
    send_word(9'h003, 2, 1'b0);
    check("ov_part_cnt", ifl.bit_cnt, 16'd2);
    @(posedge CLK); #1 clr = 1'b1; smp = 1'b1; sd = 1'b1;
    @(posedge CLK); #1 clr = 1'b0; smp = 1'b0;
    check("clr_ovr",     ifl.overrun, 16'h0);
    check("clr_cnt",     ifl.bit_cnt, 16'h0);
    check("clr_pdata",   ifl.P_Data, 16'h02);
    check("clr_dv",      ifl.data_valid, 16'h0);

    // 5-bit instance, ack coinciding with each completion
    en_a = 1'b0; en_b = 1'b1;
    send_word(9'h013, 5, 1'b1);
    check("w5a_pdata",   ifb.P_Data, 16'h13);
    check("w5a_par",     ifb.par_bit, 16'h1);
    send_word(9'h01C, 5, 1'b1);
    check("w5b_pdata",   ifb.P_Data, 16'h1C);
    check("w5b_par_ovr", {ifb.par_bit, ifb.overrun}, 16'h2);
    check("w5_a_idle",   {ifl.bit_cnt, ifl.P_Data}, 16'h02);
    idle(1);
    check("w5_dv_cnt",   dv_b, 16'd2);
    en_b = 1'b0;

    // asynchronous reset mid-word
    en_a = 1'b1;
    send_word(9'h00F, 4, 1'b0);
    check("pre_rst_cnt", ifl.bit_cnt, 16'd4);
    #2 Reset = 1'b0;
    #1;
    check("arst_pdata",  ifl.P_Data, 16'h0);
    check("arst_flags",  {ifl.bit_cnt, ifl.busy, ifl.par_bit, ifl.data_valid, ifl.overrun}, 16'h0);
    check("arst_5b",     {ifb.P_Data, ifb.par_bit}, 16'h0);
    #3 Reset = 1'b1;
    send_word(9'h05A, 8, 1'b0);
    check("post_lsb",    ifl.P_Data, 16'h5A);
    check("post_msb",    ifm.P_Data, 16'h5A);
    check("post_par",    {ifl.par_bit, ifl.overrun, ifl.data_valid}, 16'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
